// File: rtl/vid_stream_gen_pkg.sv
// Shared types and constants for the vid_stream_gen video source:
// FSM states, test-pattern codes and the LFSR seed/tap constants.
package vid_stream_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        HBLANK,
        VBLANK
    } state_t;

    typedef enum logic [2:0] {
        PAT_X_RAMP  = 3'd0,
        PAT_Y_RAMP  = 3'd1,
        PAT_XY_RAMP = 3'd2,
        PAT_CHECKER = 3'd3,
        PAT_LFSR    = 3'd4
    } pattern_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] value);
        return {value[14:0], ^(value & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/vid_stream_gen_if.sv
// Video stream bundle (pixel data, data-enable, h/v sync) between the
// generator (master) and a consumer such as the scaler (slave).
interface vid_stream_gen_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  de;
    logic                  hs;
    logic                  vs;

    modport master (output data, de, hs, vs);
    modport slave  (input  data, de, hs, vs);
endinterface

// File: rtl/vid_stream_gen_pattern.sv
// One channel of the test-pattern generator; registers a new pixel word on
// each pixel strobe. Pattern 4 (LFSR) exists only when VID_GEN_LFSR_EN is defined.
module vid_stream_gen_pattern
    import vid_stream_gen_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CNT_WIDTH-1:0]   x,
    input  logic [CNT_WIDTH-1:0]   y,
    input  logic [CNT_WIDTH-1:0]   ch,
    input  logic [2:0]             pattern,
    input  logic                   pix_strobe,
    input  logic                   frame_start,
    output logic [PIXEL_WIDTH-1:0] data
);
    logic [PIXEL_WIDTH-1:0] pix_value;

`ifdef VID_GEN_LFSR_EN
    logic [15:0]            lfsr;
    logic [PIXEL_WIDTH-1:0] lfsr_px;

    // Reseeding every frame makes each frame of an LFSR run identical
    always_ff @(posedge clk) begin
        if (!rst_n || frame_start) begin
            lfsr <= LFSR_SEED ^ 16'(ch);
        end else if (pix_strobe) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    if (PIXEL_WIDTH <= 16) begin : g_lfsr_narrow
        assign lfsr_px = lfsr[PIXEL_WIDTH-1:0];
    end else begin : g_lfsr_wide
        assign lfsr_px = {{(PIXEL_WIDTH-16){1'b0}}, lfsr};
    end
`else
    logic unused_frame_start;
    assign unused_frame_start = frame_start;
`endif

    always_comb begin
        pix_value = '0;
        case (pattern)
            PAT_X_RAMP:  pix_value = PIXEL_WIDTH'(x + ch);
            PAT_Y_RAMP:  pix_value = PIXEL_WIDTH'(y + ch);
            PAT_XY_RAMP: pix_value = PIXEL_WIDTH'(x + y + ch);
            PAT_CHECKER: pix_value = (x[3] ^ y[3]) ? '1 : '0;
`ifdef VID_GEN_LFSR_EN
            PAT_LFSR:    pix_value = lfsr_px;
`endif
            default:     pix_value = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data <= '0;
        end else if (pix_strobe) begin
            data <= pix_value;
        end
    end

endmodule

// File: rtl/vid_stream_gen.sv
// Synthesizable video stream source (frame timing FSM + per-channel patterns).
// Optional LFSR pattern enabled by defining VID_GEN_LFSR_EN.
module vid_stream_gen
    import vid_stream_gen_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int CHANNELS    = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic [CNT_WIDTH-1:0] reg_width,
    input  logic [CNT_WIDTH-1:0] reg_height,
    input  logic [CNT_WIDTH-1:0] reg_de_period,
    input  logic [CNT_WIDTH-1:0] reg_hblank,
    input  logic [CNT_WIDTH-1:0] reg_vblank,
    input  logic [CNT_WIDTH-1:0] reg_frame_count,
    input  logic [2:0]           reg_pattern,
    output logic                 busy_o,
    output logic                 frame_done_o,
    vid_stream_gen_if.master     vid
);
    state_t state, state_next;
    logic   frame_start, pix_strobe, frame_end, line_end, stop_seen;
    logic   de_r, hs_r, vs_r;

    logic [CNT_WIDTH-1:0] x, y, slot_cnt, blank_cnt, frames_done;
    logic [CNT_WIDTH-1:0] width_l, height_l, de_period_l, hblank_l, vblank_l, frame_count_l;
    logic [CNT_WIDTH-1:0] hblank_len, vblank_len;
    logic [2:0]           pattern_l;
    logic [PIXEL_WIDTH*CHANNELS-1:0] data_all;

    assign hblank_len = (hblank_l == '0) ? CNT_WIDTH'(1) : hblank_l;
    assign vblank_len = (vblank_l == '0) ? CNT_WIDTH'(1) : vblank_l;
    assign line_end   = (x == width_l - CNT_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        pix_strobe  = 1'b0;
        frame_end   = 1'b0;
        case (state)
            IDLE: begin
                if (start_i && reg_width != '0 && reg_height != '0) begin
                    state_next  = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (slot_cnt == de_period_l) begin
                    pix_strobe = 1'b1;
                    if (line_end) begin
                        state_next = (y == height_l - CNT_WIDTH'(1)) ? VBLANK : HBLANK;
                    end
                end
            end
            HBLANK: begin
                if (blank_cnt == hblank_len - CNT_WIDTH'(1)) begin
                    state_next = ACTIVE;
                end
            end
            VBLANK: begin
                if (blank_cnt == vblank_len - CNT_WIDTH'(1)) begin
                    frame_end = 1'b1;
                    // A zero-sized frame reprogrammed mid-run also ends the run
                    if (stop_seen || stop_i || reg_width == '0 || reg_height == '0 ||
                        (frame_count_l != '0 && frames_done + CNT_WIDTH'(1) == frame_count_l)) begin
                        state_next = IDLE;
                    end else begin
                        state_next  = ACTIVE;
                        frame_start = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x             <= '0;
            y             <= '0;
            slot_cnt      <= '0;
            blank_cnt     <= '0;
            frames_done   <= '0;
            stop_seen     <= 1'b0;
            width_l       <= '0;
            height_l      <= '0;
            de_period_l   <= '0;
            hblank_l      <= '0;
            vblank_l      <= '0;
            frame_count_l <= '0;
            pattern_l     <= '0;
        end else begin
            slot_cnt  <= (state == ACTIVE && !pix_strobe) ? slot_cnt + CNT_WIDTH'(1) : '0;
            blank_cnt <= (state_next == state && (state == HBLANK || state == VBLANK)) ?
                         blank_cnt + CNT_WIDTH'(1) : '0;

            if (frame_start) begin
                x             <= '0;
                y             <= '0;
                width_l       <= reg_width;
                height_l      <= reg_height;
                de_period_l   <= reg_de_period;
                hblank_l      <= reg_hblank;
                vblank_l      <= reg_vblank;
                frame_count_l <= reg_frame_count;
                pattern_l     <= reg_pattern;
            end else if (pix_strobe) begin
                if (line_end) begin
                    x <= '0;
                    y <= y + CNT_WIDTH'(1);
                end else begin
                    x <= x + CNT_WIDTH'(1);
                end
            end

            if (state == IDLE) begin
                frames_done <= '0;
                stop_seen   <= 1'b0;
            end else begin
                if (stop_i) begin
                    stop_seen <= 1'b1;
                end
                if (frame_end) begin
                    frames_done <= frames_done + CNT_WIDTH'(1);
                end
            end
        end
    end

    // One register stage keeps the sync flags aligned with the pattern data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de_r         <= 1'b0;
            hs_r         <= 1'b1;
            vs_r         <= 1'b0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            de_r         <= pix_strobe;
            hs_r         <= (state != ACTIVE);
            vs_r         <= (state == ACTIVE || state == HBLANK);
            busy_o       <= (state != IDLE);
            frame_done_o <= frame_end;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_channel
        vid_stream_gen_pattern #(
            .PIXEL_WIDTH(PIXEL_WIDTH),
            .CNT_WIDTH  (CNT_WIDTH)
        ) u_pattern (
            .clk        (clk),
            .rst_n      (rst_n),
            .x          (x),
            .y          (y),
            .ch         (CNT_WIDTH'(c)),
            .pattern    (pattern_l),
            .pix_strobe (pix_strobe),
            .frame_start(frame_start),
            .data       (data_all[c*PIXEL_WIDTH +: PIXEL_WIDTH])
        );
    end

    assign vid.data = data_all;
    assign vid.de   = de_r;
    assign vid.hs   = hs_r;
    assign vid.vs   = vs_r;

endmodule
